// File: rtl/fifo3_pkg.sv
// Shared types for the 3-lane FIFO write-side packer.
//   LANES       : number of FIFO write lanes
//   data_t      : default FIFO word type
//   lane_idx_t  : lane number / lane count (0..3)
//   req_idx_t   : producer index (up to 16 producers)
//   lane_sel_t  : which producer, if any, owns a lane this cycle
package fifo3_pkg;
  localparam int LANES      = 3;
  localparam int PKG_DATA_W = 8;
  localparam int REQ_IDX_W  = 4;

  typedef logic [PKG_DATA_W-1:0] data_t;
  typedef logic [1:0]            lane_idx_t;
  typedef logic [REQ_IDX_W-1:0]  req_idx_t;

  typedef struct packed {
    logic     valid;
    req_idx_t idx;
  } lane_sel_t;
endpackage

// File: rtl/fifo3_rr_pick.sv
// Combinational circular picker: returns the first LANES valid producers
// found scanning from rr_ptr upward, wrapping NUM_REQ-1 -> 0.
//   req_valid : per-producer request
//   rr_ptr    : highest-priority producer
//   sel       : lane k gets the (k+1)-th valid producer in scan order
module fifo3_rr_pick
  import fifo3_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [PTR_W-1:0]      rr_ptr,
  output lane_sel_t [LANES-1:0] sel
);

  always_comb begin : pick
    lane_idx_t        n;
    logic [PTR_W-1:0] p;
    sel = '0;
    n   = '0;
    p   = rr_ptr;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (req_valid[p] && (n != 2'(LANES))) begin
        sel[n].valid = 1'b1;
        sel[n].idx   = req_idx_t'(p);
        n            = n + 2'd1;
      end
      // explicit wrap keeps non-power-of-two NUM_REQ free of a modulo
      p = (p == PTR_W'(NUM_REQ - 1)) ? '0 : p + 1'b1;
    end
  end

endmodule

// File: rtl/fifo3_rr_packer.sv
// Round-robin packer sharing the three FIFO write lanes among NUM_REQ
// single-word producers, with saturating accept / block statistics.
//   clk, reset      : clock, async active-high reset
//   enable          : 0 issues nothing and freezes all state
//   req_valid/data  : producer offers; req_ready = word taken this cycle
//   fifo_data_0..2  : lane data (0 when lane unused)
//   fifo_valid      : lane valid, always a prefix (000/001/011/111)
//   fifo_able       : FIFO per-lane capacity feedback
//   rr_ptr          : current highest-priority producer
//   accept_cnt      : words accepted (saturating)
//   block_cnt       : cycles with a request but nothing accepted (saturating)
module fifo3_rr_packer
  import fifo3_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 8,
  parameter  int CNT_W   = 16,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         fifo_data_0,
  output logic [DATA_W-1:0]         fifo_data_1,
  output logic [DATA_W-1:0]         fifo_data_2,
  output logic [LANES-1:0]          fifo_valid,
  input  logic [LANES-1:0]          fifo_able,
  output logic [PTR_W-1:0]          rr_ptr,
  output logic [CNT_W-1:0]          accept_cnt,
  output logic [CNT_W-1:0]          block_cnt
);

  lane_sel_t [LANES-1:0]             sel;
  logic      [LANES-1:0]             lane_v;
  logic      [LANES-1:0]             lane_acc;
  logic      [LANES-1:0][DATA_W-1:0] lane_data;
  logic      [1:0]                   n_acc;
  logic      [PTR_W-1:0]             last_idx;
  logic      [PTR_W-1:0]             next_ptr;
  logic      [CNT_W:0]               acc_sum;

  fifo3_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .sel       (sel)
  );

  // Reset gates the lanes combinationally so outputs drop without a clock.
  always_comb begin
    for (int k = 0; k < LANES; k++)
      lane_v[k] = sel[k].valid & enable & ~reset;
  end

  // Acceptance is a running AND so a non-prefix fifo_able cannot let a
  // higher lane through past a refused lower one.
  always_comb begin
    lane_acc[0] = lane_v[0] & fifo_able[0];
    for (int k = 1; k < LANES; k++)
      lane_acc[k] = lane_acc[k-1] & lane_v[k] & fifo_able[k];
  end

  assign n_acc = lane_acc[2] ? 2'd3 :
                 lane_acc[1] ? 2'd2 :
                 lane_acc[0] ? 2'd1 : 2'd0;

  always_comb begin
    lane_data = '0;
    req_ready = '0;
    last_idx  = '0;
    for (int k = 0; k < LANES; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (lane_v[k] && (sel[k].idx == req_idx_t'(i)))
          lane_data[k] = req_data[i*DATA_W +: DATA_W];
        if (lane_acc[k] && (sel[k].idx == req_idx_t'(i)))
          req_ready[i] = 1'b1;
      end
      if (lane_acc[k])
        last_idx = sel[k].idx[PTR_W-1:0];
    end
  end

  assign fifo_valid  = lane_v;
  assign fifo_data_0 = lane_data[0];
  assign fifo_data_1 = lane_data[1];
  assign fifo_data_2 = lane_data[2];

  assign next_ptr = (last_idx == PTR_W'(NUM_REQ - 1)) ? '0 : last_idx + 1'b1;
  assign acc_sum  = {1'b0, accept_cnt} + (CNT_W+1)'(n_acc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr     <= '0;
      accept_cnt <= '0;
      block_cnt  <= '0;
    end else if (enable) begin
      if (n_acc != 2'd0)
        rr_ptr <= next_ptr;
      accept_cnt <= acc_sum[CNT_W] ? '1 : acc_sum[CNT_W-1:0];
      if (|req_valid && (n_acc == 2'd0) && (block_cnt != '1))
        block_cnt <= block_cnt + CNT_W'(1);
    end
  end

endmodule
